// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: core request/strobe and MEM handshake signals of the shared memory bus
interface mem_bus_arbiter_if;
    logic req0, req1;
    logic cs0, cs1;
    logic rd0, rd1;
    logic wr0, wr1;
    logic mem_ready;
    logic gnt0, gnt1;
    logic mem_cs, mem_rd, mem_wr;
    logic done0, done1;
    logic timeout_err;
    modport slave (
        input  req0, req1, cs0, cs1, rd0, rd1, wr0, wr1, mem_ready,
        output gnt0, gnt1, mem_cs, mem_rd, mem_wr, done0, done1, timeout_err
    );
    modport master (
        output req0, req1, cs0, cs1, rd0, rd1, wr0, wr1, mem_ready,
        input  gnt0, gnt1, mem_cs, mem_rd, mem_wr, done0, done1, timeout_err
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin exclusive grant of the shared memory bus between two cache cores
module mem_bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W = 8
) (
    input logic clk,
    input logic reset,
    mem_bus_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, OWN, TURN} state_t;
    localparam logic [CNT_W-1:0] LIM = CNT_W'(TIMEOUT_CYCLES - 1);
    state_t r_state;
    logic r_gnt0, r_gnt1, r_last, r_timeout_err;
    logic [CNT_W-1:0] r_cnt;
    logic w_own_cs, w_own_rd, w_own_wr, w_own_req, w_xfer_done, w_winner, w_any_req;
    // Owner mux and next-owner choice; IDLE and TURN share the same pick (prefer ~last, else whoever asks)
    always_comb begin
        w_own_cs = r_gnt0 ? bus.cs0 : r_gnt1 ? bus.cs1 : 1'b0;
        w_own_rd = r_gnt0 ? bus.rd0 : r_gnt1 ? bus.rd1 : 1'b0;
        w_own_wr = r_gnt0 ? bus.wr0 : r_gnt1 ? bus.wr1 : 1'b0;
        w_own_req = r_gnt1 ? bus.req1 : bus.req0;
        w_xfer_done = bus.mem_ready & w_own_cs & ~reset;
        w_winner = (bus.req0 & bus.req1) ? ~r_last : bus.req1;
        w_any_req = bus.req0 | bus.req1;
    end
    assign bus.gnt0 = r_gnt0;
    assign bus.gnt1 = r_gnt1;
    assign bus.mem_cs = w_own_cs & ~reset;
    assign bus.mem_wr = w_own_wr & ~reset;
    assign bus.mem_rd = w_own_rd & ~w_own_wr & ~reset;
    assign bus.done0 = w_xfer_done & r_gnt0;
    assign bus.done1 = w_xfer_done & r_gnt1;
    assign bus.timeout_err = r_timeout_err;
    // Grant FSM: registered one-hot grant, round-robin pointer, cs watchdog with one dead TURN cycle on release
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_gnt0 <= 1'b0;
            r_gnt1 <= 1'b0;
            r_last <= 1'b1;
            r_cnt <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            case (r_state)
                IDLE, TURN: begin
                    if (w_any_req) begin
                        r_state <= OWN;
                        r_gnt0 <= ~w_winner;
                        r_gnt1 <= w_winner;
                        r_last <= w_winner;
                        r_cnt <= '0;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                OWN: begin
                    if (w_xfer_done || !w_own_req) begin
                        r_state <= TURN;
                        r_gnt0 <= 1'b0;
                        r_gnt1 <= 1'b0;
                    end else if (w_own_cs) begin
                        if (r_cnt == LIM) begin
                            r_timeout_err <= 1'b1;
                            r_state <= TURN;
                            r_gnt0 <= 1'b0;
                            r_gnt1 <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_gnt0 <= 1'b0;
                    r_gnt1 <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: scoreboard bench for the two-core memory bus arbiter
module tb_mem_bus_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int tests = 0;
    int fails = 0;
    int exp_q[$], act_q[$], gnt_q[$], gap_q[$];
    int onehot_viol = 0, zero_run = 0, hang = 0, seen = 0, lat = 2;
    bit had_gnt = 0, prev_any = 0, mem_auto = 0;
    logic auto_ready = 1'b0, man_ready = 1'b0;

    mem_bus_arbiter_if bus ();
    mem_bus_arbiter #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (.clk(clk), .reset(reset), .bus(bus));

    assign bus.mem_ready = mem_auto ? auto_ready : man_ready;

    always #5 clk = ~clk;

    // Monitor: record done events, grant order, dead cycles between grants, one-hot violations
    always @(negedge clk) begin
        if (bus.done0) act_q.push_back(0);
        if (bus.done1) act_q.push_back(1);
        if (bus.gnt0 & bus.gnt1) onehot_viol++;
        if (bus.gnt0 | bus.gnt1) begin
            if (!prev_any) begin
                gnt_q.push_back(bus.gnt1 ? 1 : 0);
                if (had_gnt) gap_q.push_back(zero_run);
            end
            zero_run = 0;
            had_gnt = 1;
        end else begin
            zero_run++;
        end
        prev_any = bus.gnt0 | bus.gnt1;
    end

    // MEM model: ready after cs has been seen for lat cycles
    initial forever begin
        @(posedge clk);
        #2;
        if (bus.mem_cs && !auto_ready) begin
            if (seen >= lat - 1) auto_ready = 1'b1;
            else seen++;
        end else begin
            auto_ready = 1'b0;
            seen = 0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int c, input logic q, input logic s, input logic r, input logic w);
        if (c == 0) begin
            bus.req0 = q; bus.cs0 = s; bus.rd0 = r; bus.wr0 = w;
        end else begin
            bus.req1 = q; bus.cs1 = s; bus.rd1 = r; bus.wr1 = w;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        man_ready = 1'b0;
        mem_auto = 0;
        tick();
        tick();
        reset = 1'b0;
        exp_q.delete(); act_q.delete(); gnt_q.delete(); gap_q.delete();
        onehot_viol = 0; zero_run = 0; hang = 0; had_gnt = 0; prev_any = 0;
    endtask

    task automatic core_run(input int c, input int n);
        bit got;
        for (int k = 0; k < n; k++) begin
            got = 0;
            drive(c, 1, 1, 1, 0);
            for (int t = 0; t < 60 && !got; t++) begin
                @(posedge clk);
                #3;
                got = (c == 0) ? bus.done0 : bus.done1;
            end
            if (!got) hang++;
            tick();
        end
        drive(c, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if ({bus.gnt0, bus.gnt1, bus.mem_cs, bus.mem_rd, bus.mem_wr, bus.done0, bus.done1, bus.timeout_err} !== 8'b0) begin
            fails++;
            $display("FAIL reset_outputs: got %b want 00000000",
                {bus.gnt0, bus.gnt1, bus.mem_cs, bus.mem_rd, bus.mem_wr, bus.done0, bus.done1, bus.timeout_err});
        end
    endtask

    task automatic test_single();
        int e, a;
        do_reset();
        drive(0, 1, 1, 1, 0);
        exp_q.push_back(0);
        tick();
        tests++;
        if ({bus.gnt0, bus.gnt1} !== 2'b10) begin
            fails++; $display("FAIL single_gnt: got %b want 10", {bus.gnt0, bus.gnt1});
        end
        tests++;
        if ({bus.mem_cs, bus.mem_rd, bus.mem_wr} !== 3'b110) begin
            fails++; $display("FAIL single_strobes: got %b want 110", {bus.mem_cs, bus.mem_rd, bus.mem_wr});
        end
        tick();
        tick();
        man_ready = 1'b1;
        #1;
        tests++;
        if ({bus.done0, bus.done1} !== 2'b10) begin
            fails++; $display("FAIL single_done: got %b want 10", {bus.done0, bus.done1});
        end
        tick();
        drive(0, 0, 0, 0, 0);
        man_ready = 1'b0;
        tests++;
        if ({bus.gnt0, bus.gnt1} !== 2'b00) begin
            fails++; $display("FAIL single_release: got %b want 00", {bus.gnt0, bus.gnt1});
        end
        tick();
        tick();
        tests++;
        if (act_q.size() != exp_q.size()) begin
            fails++; $display("FAIL single_done_count: got %0d want %0d", act_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = (act_q.size() > 0) ? act_q.pop_front() : -1;
            tests++;
            if (a !== e) begin
                fails++; $display("FAIL single_done_owner: got %0d want %0d", a, e);
            end
        end
    endtask

    task automatic test_tie();
        int e, a;
        do_reset();
        mem_auto = 1;
        lat = 2;
        exp_q.push_back(0);
        exp_q.push_back(1);
        fork
            core_run(0, 1);
            core_run(1, 1);
        join
        tick();
        tick();
        tests++;
        if (hang != 0) begin
            fails++; $display("FAIL tie_bound: got %0d expired waits want 0", hang);
        end
        tests++;
        if (act_q.size() != exp_q.size()) begin
            fails++; $display("FAIL tie_done_count: got %0d want %0d", act_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = (act_q.size() > 0) ? act_q.pop_front() : -1;
            tests++;
            if (a !== e) begin
                fails++; $display("FAIL tie_order: got %0d want %0d", a, e);
            end
        end
        tests++;
        if (gap_q.size() != 1 || gap_q[0] != 1) begin
            fails++; $display("FAIL tie_turn_gap: got %0d gaps first %0d want 1 gap of 1",
                gap_q.size(), (gap_q.size() > 0) ? gap_q[0] : -1);
        end
        tests++;
        if (onehot_viol != 0) begin
            fails++; $display("FAIL tie_onehot: got %0d violations want 0", onehot_viol);
        end
    endtask

    task automatic test_back_to_back();
        int e, a, g;
        bit last;
        do_reset();
        mem_auto = 1;
        lat = 2;
        last = 1;
        for (int k = 0; k < 6; k++) begin
            exp_q.push_back(last ? 0 : 1);
            last = ~last;
        end
        fork
            core_run(0, 3);
            core_run(1, 3);
        join
        tick();
        tick();
        tests++;
        if (hang != 0) begin
            fails++; $display("FAIL b2b_bound: got %0d expired waits want 0", hang);
        end
        tests++;
        if (act_q.size() != 6 || gnt_q.size() != 6) begin
            fails++; $display("FAIL b2b_count: got %0d dones %0d grants want 6 6", act_q.size(), gnt_q.size());
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = (act_q.size() > 0) ? act_q.pop_front() : -1;
            g = (gnt_q.size() > 0) ? gnt_q.pop_front() : -1;
            tests++;
            if (a !== e || g !== e) begin
                fails++; $display("FAIL b2b_order: got done %0d gnt %0d want %0d", a, g, e);
            end
        end
        tests++;
        if (onehot_viol != 0) begin
            fails++; $display("FAIL b2b_onehot: got %0d violations want 0", onehot_viol);
        end
    endtask

    task automatic test_isolation();
        do_reset();
        drive(1, 1, 1, 0, 0);
        drive(0, 0, 1, 0, 1);
        tick();
        tests++;
        if ({bus.gnt0, bus.gnt1} !== 2'b01) begin
            fails++; $display("FAIL iso_gnt: got %b want 01", {bus.gnt0, bus.gnt1});
        end
        tests++;
        if ({bus.mem_cs, bus.mem_rd, bus.mem_wr} !== 3'b100) begin
            fails++; $display("FAIL iso_owner_only: got %b want 100", {bus.mem_cs, bus.mem_rd, bus.mem_wr});
        end
        drive(1, 1, 0, 0, 0);
        #1;
        tests++;
        if ({bus.mem_cs, bus.mem_rd, bus.mem_wr} !== 3'b000) begin
            fails++; $display("FAIL iso_other_cs: got %b want 000", {bus.mem_cs, bus.mem_rd, bus.mem_wr});
        end
        drive(1, 1, 1, 1, 1);
        #1;
        tests++;
        if ({bus.mem_cs, bus.mem_rd, bus.mem_wr} !== 3'b101) begin
            fails++; $display("FAIL iso_rd_wr: got %b want 101", {bus.mem_cs, bus.mem_rd, bus.mem_wr});
        end
        drive(1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        tick();
        tests++;
        if ({bus.gnt0, bus.gnt1} !== 2'b00) begin
            fails++; $display("FAIL iso_abandon: got %b want 00", {bus.gnt0, bus.gnt1});
        end
        tick();
    endtask

    task automatic test_timeout();
        do_reset();
        drive(0, 1, 1, 1, 0);
        drive(1, 1, 0, 0, 0);
        tick();
        tick();
        tick();
        tick();
        tests++;
        if ({bus.timeout_err, bus.gnt0} !== 2'b01) begin
            fails++; $display("FAIL to_before: got %b want 01", {bus.timeout_err, bus.gnt0});
        end
        tick();
        tests++;
        if ({bus.timeout_err, bus.gnt0, bus.gnt1} !== 3'b100) begin
            fails++; $display("FAIL to_expire: got %b want 100", {bus.timeout_err, bus.gnt0, bus.gnt1});
        end
        tick();
        tests++;
        if ({bus.gnt0, bus.gnt1} !== 2'b01) begin
            fails++; $display("FAIL to_next_owner: got %b want 01", {bus.gnt0, bus.gnt1});
        end
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        tick();
        tick();
        tests++;
        if (bus.timeout_err !== 1'b1 || act_q.size() != 0) begin
            fails++; $display("FAIL to_sticky: got err %b dones %0d want 1 0", bus.timeout_err, act_q.size());
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tests++;
        if (bus.timeout_err !== 1'b0) begin
            fails++; $display("FAIL to_clear: got %b want 0", bus.timeout_err);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(0, 1, 1, 1, 0);
        tick();
        tick();
        reset = 1'b1;
        man_ready = 1'b1;
        #1;
        tests++;
        if ({bus.done0, bus.done1} !== 2'b00) begin
            fails++; $display("FAIL rst_mid_ready_ignored: got %b want 00", {bus.done0, bus.done1});
        end
        tick();
        reset = 1'b0;
        #1;
        tests++;
        if ({bus.gnt0, bus.gnt1, bus.mem_cs, bus.mem_rd, bus.mem_wr, bus.done0, bus.done1, bus.timeout_err} !== 8'b0) begin
            fails++;
            $display("FAIL rst_mid_outputs: got %b want 00000000",
                {bus.gnt0, bus.gnt1, bus.mem_cs, bus.mem_rd, bus.mem_wr, bus.done0, bus.done1, bus.timeout_err});
        end
        man_ready = 1'b0;
        drive(1, 1, 0, 0, 0);
        tick();
        tests++;
        if ({bus.gnt0, bus.gnt1} !== 2'b10) begin
            fails++; $display("FAIL rst_mid_tie: got %b want 10", {bus.gnt0, bus.gnt1});
        end
        tests++;
        if (act_q.size() != 0) begin
            fails++; $display("FAIL rst_mid_no_done: got %0d dones want 0", act_q.size());
        end
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_back_to_back();
        test_isolation();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
